// File: rtl/dmem_pkg.sv
// Shared encodings and sizes for the MEM-stage data memory access block.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNT_W           = 8;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory access; flags the last allowed cycle.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data memory access controller: latches a load/store, holds the
// request until ack or timeout, captures load data into the MDR and stalls the pipeline.
module dmem_access
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] mdr_o,
  output logic        stall_o,
  output logic        err_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;

  logic op, aligned, cnt_clear, cnt_en, cnt_expired;

  assign op      = MemRead_i | MemWrite_i;
  assign aligned = is_word_aligned(addr_i);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cnt_clear),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    mdr_d     = mdr_q;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op && aligned) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          we_d      = MemWrite_i;  // read+write together is a store
          cnt_clear = 1'b1;
          state_d   = ST_ACCESS;
        end else if (op) begin
          err_d = 1'b1;
          if (!MemWrite_i) mdr_d = '0;
        end
      end
      ST_ACCESS: begin
        // An ack on the expiry cycle takes priority over the timeout.
        if (mem_ack_i) begin
          if (!we_q) mdr_d = mem_rdata_i;
          state_d = ST_DONE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          if (!we_q) mdr_d = '0;
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = (state_q == ST_ACCESS);
  assign mem_we_o    = (state_q == ST_ACCESS) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mdr_o       = mdr_q;
  assign err_o       = err_q;
  assign stall_o     = ((state_q == ST_IDLE) & op & aligned) | (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: loads, stores, timeout, misalignment, reset mid-access.
module tb_dmem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mdr_o;

  int checks   = 0;
  int failures = 0;

  dmem_access #(.TIMEOUT(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mdr_o       (mdr_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; mem_rdata_i = 32'h0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    step(); step();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_mdr", mdr_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;
    step();
    chk("post_rst_stall", {31'd0, stall_o}, 32'd0);

    // Load 0x10, ack in first ACCESS cycle
    MemRead_i = 1'b1; addr_i = 32'h10; #1;
    chk("ld_idle_stall", {31'd0, stall_o}, 32'd1);
    chk("ld_idle_req", {31'd0, mem_req_o}, 32'd0);
    step();
    chk("ld_acc_req", {31'd0, mem_req_o}, 32'd1);
    chk("ld_acc_we", {31'd0, mem_we_o}, 32'd0);
    chk("ld_acc_addr", mem_addr_o, 32'h10);
    chk("ld_acc_stall", {31'd0, stall_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    step();
    chk("ld_done_stall", {31'd0, stall_o}, 32'd0);
    chk("ld_done_mdr", mdr_o, 32'hCAFEF00D);
    chk("ld_done_err", {31'd0, err_o}, 32'd0);
    chk("ld_done_req", {31'd0, mem_req_o}, 32'd0);
    idle_inputs();
    step();
    chk("ld_back_idle_stall", {31'd0, stall_o}, 32'd0);

    // Store 0x20, ack on 4th ACCESS cycle
    MemWrite_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678;
    step();
    addr_i = 32'hFFFF_FFF0; wdata_i = 32'h0;  // latched values must not follow the inputs
    for (int i = 0; i < 4; i++) begin
      chk("st_acc_req", {31'd0, mem_req_o}, 32'd1);
      chk("st_acc_we", {31'd0, mem_we_o}, 32'd1);
      chk("st_acc_addr", mem_addr_o, 32'h20);
      chk("st_acc_wdata", mem_wdata_o, 32'h12345678);
      chk("st_acc_stall", {31'd0, stall_o}, 32'd1);
      if (i == 3) begin
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      end
      step();
    end
    chk("st_done_mdr", mdr_o, 32'hCAFEF00D);
    chk("st_done_err", {31'd0, err_o}, 32'd0);
    chk("st_done_req", {31'd0, mem_req_o}, 32'd0);
    chk("st_done_we", {31'd0, mem_we_o}, 32'd0);
    idle_inputs();
    step();

    // Load with no ack: 16 ACCESS cycles then DONE with err and mdr=0
    MemRead_i = 1'b1; addr_i = 32'h30;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("to_acc_req", {31'd0, mem_req_o}, 32'd1);
      chk("to_acc_stall", {31'd0, stall_o}, 32'd1);
      step();
    end
    chk("to_done_req", {31'd0, mem_req_o}, 32'd0);
    chk("to_done_err", {31'd0, err_o}, 32'd1);
    chk("to_done_mdr", mdr_o, 32'd0);
    chk("to_done_stall", {31'd0, stall_o}, 32'd0);
    idle_inputs();
    step();
    chk("to_err_clear", {31'd0, err_o}, 32'd0);

    // Ack on the timeout cycle wins
    MemRead_i = 1'b1; addr_i = 32'h40;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("race_acc_req", {31'd0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    step();
    chk("race_done_err", {31'd0, err_o}, 32'd0);
    chk("race_done_mdr", mdr_o, 32'h55AA55AA);
    idle_inputs();
    step();

    // Ack in IDLE is ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    step();
    chk("idle_ack_mdr", mdr_o, 32'h55AA55AA);
    chk("idle_ack_req", {31'd0, mem_req_o}, 32'd0);
    idle_inputs();

    // Misaligned load 0x13
    MemRead_i = 1'b1; addr_i = 32'h13; #1;
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    chk("mis_req", {31'd0, mem_req_o}, 32'd0);
    step();
    idle_inputs(); #1;
    chk("mis_err", {31'd0, err_o}, 32'd1);
    chk("mis_mdr", mdr_o, 32'd0);
    chk("mis_req2", {31'd0, mem_req_o}, 32'd0);
    chk("mis_stall2", {31'd0, stall_o}, 32'd0);
    step();
    chk("mis_err_once", {31'd0, err_o}, 32'd0);

    // Read and write together act as a store
    MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h44; wdata_i = 32'hA5A5A5A5;
    step();
    chk("rw_we", {31'd0, mem_we_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
    step();
    chk("rw_mdr", mdr_o, 32'd0);
    idle_inputs();
    step();

    // Back-to-back loads, reset in 2nd ACCESS cycle of the second
    MemRead_i = 1'b1; addr_i = 32'h50;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    step();
    chk("b2b_first_mdr", mdr_o, 32'h11111111);
    chk("b2b_first_err", {31'd0, err_o}, 32'd0);
    mem_ack_i = 1'b0; addr_i = 32'h54;
    step();
    chk("b2b_idle_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("b2b_acc1_req", {31'd0, mem_req_o}, 32'd1);
    step();
    chk("b2b_acc2_req", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
    step();
    rst_i = 1'b0; MemRead_i = 1'b0; #1;
    chk("b2b_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("b2b_rst_mdr", mdr_o, 32'd0);
    chk("b2b_rst_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("b2b_late_ack_mdr", mdr_o, 32'd0);
    chk("b2b_late_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("b2b_late_ack_err", {31'd0, err_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles in ACCESS without mem_ack_i before the access is aborted; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 MemRead_i  input  1  load request from the EX/MEM stage register.
REQ-005 MemWrite_i  input  1  store request from the EX/MEM stage register.
REQ-006 addr_i  input  32  byte address (ALU result).
REQ-007 wdata_i  input  32  store data.
REQ-008 mem_ack_i  input  1  data memory completion strobe; valid only in ACCESS.
REQ-009 mem_rdata_i  input  32  load data; valid when mem_ack_i=1.
REQ-010 mem_req_o  output  1  request to data memory.
REQ-011 mem_we_o  output  1  1 = store, 0 = load; meaningful while mem_req_o=1.
REQ-012 mem_addr_o, mem_wdata_o  output  32 each  latched address and store data.
REQ-013 mdr_o  output  32  memory data register; feeds the MEM/WB mdr input.
REQ-014 stall_o  output  1  freeze request to PC, IF/ID, ID/EX, EX/MEM and MEM/WB; the MEM/WB enable equals ~stall_o.
REQ-015 err_o  output  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and DONE, and SHALL reset to IDLE.
REQ-017 In IDLE, op = MemRead_i|MemWrite_i; when op=1 and addr_i[1:0]=0, the block SHALL latch addr_i, wdata_i and we=MemWrite_i, and go to ACCESS.
REQ-018 When MemRead_i and MemWrite_i are both 1, the access SHALL be treated as a store.
REQ-019 stall_o SHALL be combinational: 1 in IDLE with an aligned op, 1 throughout ACCESS, otherwise 0.
REQ-020 In ACCESS, mem_req_o SHALL be 1, and mem_addr_o, mem_wdata_o and mem_we_o SHALL hold their latched values.
REQ-021 In ACCESS with mem_ack_i=1: on a load, mdr_o SHALL load mem_rdata_i; on a store, mdr_o SHALL be unchanged; the next state SHALL be DONE.
REQ-022 DONE SHALL last exactly one cycle with stall_o=0, so the pipeline advances; the next state SHALL be IDLE.
REQ-023 Minimum latency SHALL be 3 cycles (IDLE, ACCESS with ack, DONE); each extra cycle without ack SHALL add one cycle.
REQ-024 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-025 When the wait counter reaches TIMEOUT-1 with no ack: the next state SHALL be DONE, mdr_o SHALL load 0 on a load, and err_o SHALL pulse in the DONE cycle.
REQ-026 An ack arriving in the same cycle as the timeout SHALL win: normal completion, no err_o.
REQ-027 Misaligned op in IDLE: no memory request and no stall; err_o SHALL pulse in the next cycle; mdr_o SHALL load 0 on a load; the state SHALL stay IDLE.
REQ-028 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-029 mdr_o SHALL hold its value when no load completes.
REQ-030 mem_req_o, mem_we_o and err_o SHALL be 0 outside the states stated above.

Reset
REQ-031 While rst_i=1 at a clock edge: state=IDLE, wait counter=0, mdr_o=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, err_o=0.
REQ-032 Reset asserted mid-ACCESS SHALL drop mem_req_o from the next cycle; an ack in the reset cycle SHALL be discarded.
REQ-033 stall_o SHALL read 0 in the cycle after reset unless an aligned op is present.

Structure
REQ-034 Package dmem_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), the TIMEOUT default and the counter width (8).
REQ-035 The wait counter SHALL be a sub-module, dmem_timeout_cnt, with clear, enable and expired ports; the FSM and datapath registers stay in dmem_access.

Verification
REQ-036 Load: addr=0x10, ack in the first ACCESS cycle with rdata=0xCAFEF00D -> stall_o=1 for 2 cycles, mdr_o=0xCAFEF00D in DONE, err_o=0.
REQ-037 Store: addr=0x20, wdata=0x12345678, ack after 4 cycles -> mem_we_o=1 and address/data stable for 4 ACCESS cycles, mdr_o unchanged.
REQ-038 Load with no ack, TIMEOUT=16 -> 16 ACCESS cycles, then DONE with err_o=1 and mdr_o=0.
REQ-039 Misaligned load, addr=0x13 -> mem_req_o never 1, stall_o=0, err_o pulses once, mdr_o=0.
REQ-040 Back-to-back loads plus rst_i raised in the 2nd ACCESS cycle of the second load -> first load completes normally; after reset state=IDLE, mem_req_o=0, and a late ack is ignored.
